term_char_writer: RTL and testbench

//  Parametrised terminal front-end between uart_rx byte stream and vga_ascii char buffer.

---
 rtl/term_char_writer_if.sv | 37 +++
 rtl/term_char_writer.sv | 219 +++++++++++++++++++++
 tb/tb_term_char_writer.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/term_char_writer_if.sv
`default_nettype none
// ============================================================================
//  Module      : term_char_writer_if
//  Description : Bundles the receive handshake, the character-buffer write
//                port and the cursor/status outputs of term_char_writer.
//                master = byte source / buffer sink side (testbench, system),
//                slave  = term_char_writer side.
//  Signals     : rx_data[7:0], rx_valid, rx_ready       (byte stream in)
//                wr_en, wr_addr[AW-1:0], wr_data[7:0]   (buffer write out)
//                cur_x, cur_y, cur_addr [AW-1:0], busy  (cursor / status)
//  Revision    : 1.0 - initial release
// ============================================================================
interface term_char_writer_if #(
    parameter int AW = 13
);
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [AW-1:0] cur_x;
    logic [AW-1:0] cur_y;
    logic [AW-1:0] cur_addr;
    logic          busy;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, wr_en, wr_addr, wr_data, cur_x, cur_y, cur_addr, busy
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, wr_en, wr_addr, wr_data, cur_x, cur_y, cur_addr, busy
    );
endinterface
`default_nettype wire

// File: rtl/term_char_writer.sv
`default_nettype none
// ============================================================================
//  Module      : term_char_writer
//  Description : Terminal front-end between a uart_rx byte stream and a
//                vga_ascii character buffer. Decodes printable and control
//                bytes plus ANSI CSI sequences (ESC [ ...), tracks a cursor
//                and issues single-cycle buffer writes. Includes backspace,
//                home and a hardware clear-screen sweep that back-pressures rx.
//  Ports       : clk, rst (async, active-high)
//                bus (term_char_writer_if.slave): rx_data/rx_valid/rx_ready,
//                wr_en/wr_addr/wr_data, cur_x/cur_y/cur_addr, busy
//  Options     : TERM_CSI_COUNT_EN - decimal CSI argument (repeat count for
//                A/B/C/D, selector for J). Undefined: single steps, J clears.
//  Revision    : 1.0 - initial release
// ============================================================================
module term_char_writer #(
    parameter int COLS    = 80,
    parameter int ROWS    = 60,
    parameter int AW      = 13,
    parameter int CNT_MAX = 99
) (
    input  wire logic          clk,
    input  wire logic          rst,
    term_char_writer_if.slave  bus
);
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ESC   = 2'd1;
    localparam logic [1:0] c_CSI   = 2'd2;
    localparam logic [1:0] c_CLEAR = 2'd3;

    localparam int            c_AW1    = AW + 1;
    localparam logic [AW:0]   c_COLS_W = c_AW1'(COLS);
    localparam logic [AW:0]   c_ROWS_W = c_AW1'(ROWS);
    localparam logic [AW-1:0] c_COLS_A = AW'(COLS);
    localparam logic [AW-1:0] c_X_LAST = AW'(COLS - 1);
    localparam logic [AW-1:0] c_Y_LAST = AW'(ROWS - 1);
    localparam logic [AW-1:0] c_A_LAST = AW'(COLS * ROWS - 1);

    generate
        if ((COLS * ROWS > (2 ** AW)) || (CNT_MAX < 1)) begin : g_param_check
            $error("term_char_writer: COLS*ROWS must fit in AW bits and CNT_MAX >= 1");
        end
    endgenerate

    logic [1:0]    r_state;
    logic [AW-1:0] r_x, r_y, r_addr, r_clr;
    logic          r_wr_en;
    logic [AW-1:0] r_wr_addr;
    logic [7:0]    r_wr_data;

    logic [1:0]    w_nstate;
    logic [AW-1:0] w_nx, w_ny;
    logic          w_print;
    logic          w_accept;
    logic          w_j_ok;
    logic [AW:0]   w_step_x, w_step_y;
    logic [AW:0]   w_x_ext, w_y_ext;
    logic [AW:0]   w_right, w_left, w_down, w_up;

    assign w_accept = bus.rx_valid && (r_state != c_CLEAR);

`ifdef TERM_CSI_COUNT_EN
    // Accumulator is 4 bits wider than the argument so arg*10+9 never wraps
    // before the saturation compare.
    localparam int c_AGW = $clog2(CNT_MAX + 1);
    localparam int c_ACW = c_AGW + 4;

    logic [c_AGW-1:0] r_arg;
    logic [c_ACW-1:0] w_arg_ext, w_arg_acc;
    logic [c_AGW-1:0] w_arg_sat, w_arg_n;
    logic             w_csi_start, w_is_digit;

    assign w_csi_start = (r_state == c_ESC) && w_accept && (bus.rx_data == 8'h5B);
    assign w_is_digit  = (r_state == c_CSI) && w_accept &&
                         (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
    assign w_arg_ext   = {4'b0000, r_arg};
    assign w_arg_acc   = (w_arg_ext << 3) + (w_arg_ext << 1) +
                         {{(c_ACW-4){1'b0}}, bus.rx_data[3:0]};
    assign w_arg_sat   = (w_arg_acc > c_ACW'(CNT_MAX)) ? c_AGW'(CNT_MAX) : w_arg_acc[c_AGW-1:0];
    // Absent or zero argument means one step.
    assign w_arg_n     = (r_arg == '0) ? c_AGW'(1) : r_arg;
    assign w_step_x    = c_AW1'(w_arg_n) % c_COLS_W;
    assign w_step_y    = c_AW1'(w_arg_n) % c_ROWS_W;
    assign w_j_ok      = (r_arg == '0) || (r_arg == c_AGW'(2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_arg <= '0;
        end else if (w_csi_start) begin
            r_arg <= '0;
        end else if (w_is_digit) begin
            r_arg <= w_arg_sat;
        end
    end
`else
    assign w_step_x = c_AW1'(1);
    assign w_step_y = c_AW1'(1);
    assign w_j_ok   = 1'b1;
`endif

    // Steps are already reduced below COLS/ROWS, so one conditional
    // add/subtract of the modulus wraps correctly.
    assign w_x_ext = {1'b0, r_x};
    assign w_y_ext = {1'b0, r_y};
    assign w_right = (w_x_ext + w_step_x >= c_COLS_W) ? w_x_ext + w_step_x - c_COLS_W
                                                     : w_x_ext + w_step_x;
    assign w_left  = (w_x_ext >= w_step_x) ? w_x_ext - w_step_x
                                           : w_x_ext + c_COLS_W - w_step_x;
    assign w_down  = (w_y_ext + w_step_y >= c_ROWS_W) ? w_y_ext + w_step_y - c_ROWS_W
                                                     : w_y_ext + w_step_y;
    assign w_up    = (w_y_ext >= w_step_y) ? w_y_ext - w_step_y
                                           : w_y_ext + c_ROWS_W - w_step_y;

    always_comb begin
        w_nstate = r_state;
        w_nx     = r_x;
        w_ny     = r_y;
        w_print  = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    if ((bus.rx_data >= 8'h20) && (bus.rx_data <= 8'h7E)) begin
                        w_print = 1'b1;
                        if (r_x == c_X_LAST) begin
                            w_nx = '0;
                            w_ny = (r_y == c_Y_LAST) ? '0 : r_y + 1'b1;
                        end else begin
                            w_nx = r_x + 1'b1;
                        end
                    end else if (bus.rx_data == 8'h0D) begin
                        w_nx = '0;
                    end else if (bus.rx_data == 8'h0A) begin
                        w_ny = (r_y == c_Y_LAST) ? '0 : r_y + 1'b1;
                    end else if (bus.rx_data == 8'h08) begin
                        w_nx = (r_x == '0) ? '0 : r_x - 1'b1;
                    end else if (bus.rx_data == 8'h1B) begin
                        w_nstate = c_ESC;
                    end
                end
            end
            c_ESC: begin
                if (w_accept) begin
                    w_nstate = (bus.rx_data == 8'h5B) ? c_CSI : c_IDLE;
                end
            end
            c_CSI: begin
                if (w_accept) begin
                    if ((bus.rx_data < 8'h20) || (bus.rx_data >= 8'h7F)) begin
                        w_nstate = c_IDLE;
                    end else if (bus.rx_data >= 8'h40) begin
                        w_nstate = c_IDLE;
                        case (bus.rx_data)
                            8'h41:   w_ny = w_up[AW-1:0];
                            8'h42:   w_ny = w_down[AW-1:0];
                            8'h43:   w_nx = w_right[AW-1:0];
                            8'h44:   w_nx = w_left[AW-1:0];
                            8'h48: begin
                                w_nx = '0;
                                w_ny = '0;
                            end
                            8'h4A: begin
                                if (w_j_ok) begin
                                    w_nstate = c_CLEAR;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
            c_CLEAR: begin
                if (r_clr == c_A_LAST) begin
                    w_nstate = c_IDLE;
                    w_nx     = '0;
                    w_ny     = '0;
                end
            end
            default: w_nstate = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_x       <= '0;
            r_y       <= '0;
            r_addr    <= '0;
            r_clr     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_state <= w_nstate;
            r_x     <= w_nx;
            r_y     <= w_ny;
            r_addr  <= w_ny * c_COLS_A + w_nx;
            r_clr   <= ((r_state == c_CLEAR) && (r_clr != c_A_LAST)) ? r_clr + 1'b1 : '0;
            r_wr_en <= w_print || (r_state == c_CLEAR);
            // Write port holds its last address/data when idle.
            if (w_print) begin
                r_wr_addr <= r_addr;
                r_wr_data <= bus.rx_data;
            end else if (r_state == c_CLEAR) begin
                r_wr_addr <= r_clr;
                r_wr_data <= 8'h20;
            end
        end
    end

    assign bus.rx_ready = (r_state != c_CLEAR);
    assign bus.busy     = (r_state == c_CLEAR);
    assign bus.wr_en    = r_wr_en;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;
    assign bus.cur_x    = r_x;
    assign bus.cur_y    = r_y;
    assign bus.cur_addr = r_addr;
endmodule
`default_nettype wire

// File: tb/tb_term_char_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_term_char_writer
//  Description : Self-checking bench for term_char_writer. A byte-level
//                terminal model predicts cursor position and the ordered list
//                of buffer writes; a monitor collects the DUT's writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_term_char_writer;
    localparam int COLS    = 80;
    localparam int ROWS    = 60;
    localparam int AW      = 13;
    localparam int CNT_MAX = 99;
    localparam int NCELL   = COLS * ROWS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    term_char_writer_if #(.AW(AW)) bus ();

    term_char_writer #(.COLS(COLS), .ROWS(ROWS), .AW(AW), .CNT_MAX(CNT_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [AW+7:0] got_q[$];
    logic [AW+7:0] exp_q[$];

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) got_q.push_back({bus.wr_addr, bus.wr_data});
    end

    // ---------------- reference terminal model ----------------
    int mx, my, mmode, marg;

    function automatic void model_reset();
        mx = 0; my = 0; mmode = 0; marg = 0;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        int n;
        bit clears;
        logic [AW-1:0] a;
`ifdef TERM_CSI_COUNT_EN
        n      = (marg == 0) ? 1 : marg;
        clears = (marg == 0) || (marg == 2);
`else
        n      = 1;
        clears = 1'b1;
`endif
        if (mmode == 0) begin
            if (b >= 8'h20 && b <= 8'h7E) begin
                a = AW'(my * COLS + mx);
                exp_q.push_back({a, b});
                mx = mx + 1;
                if (mx == COLS) begin mx = 0; my = (my + 1) % ROWS; end
            end else if (b == 8'h0D) mx = 0;
            else if (b == 8'h0A) my = (my + 1) % ROWS;
            else if (b == 8'h08) begin if (mx > 0) mx = mx - 1; end
            else if (b == 8'h1B) mmode = 1;
        end else if (mmode == 1) begin
            if (b == 8'h5B) begin mmode = 2; marg = 0; end
            else mmode = 0;
        end else begin
            if (b < 8'h20 || b >= 8'h7F) mmode = 0;
            else if (b <= 8'h3F) begin
                if (b >= 8'h30 && b <= 8'h39) begin
`ifdef TERM_CSI_COUNT_EN
                    marg = marg * 10 + (int'(b) - 48);
                    if (marg > CNT_MAX) marg = CNT_MAX;
`endif
                end
            end else begin
                mmode = 0;
                case (b)
                    8'h41: my = ((my - n) % ROWS + ROWS) % ROWS;
                    8'h42: my = (my + n) % ROWS;
                    8'h43: mx = (mx + n) % COLS;
                    8'h44: mx = ((mx - n) % COLS + COLS) % COLS;
                    8'h48: begin mx = 0; my = 0; end
                    8'h4A: if (clears) begin
                        for (int i = 0; i < NCELL; i++) begin
                            a = AW'(i);
                            exp_q.push_back({a, 8'h20});
                        end
                        mx = 0; my = 0;
                    end
                    default: ;
                endcase
            end
        end
    endfunction

    // Index of first difference between collected and predicted writes, -1 if identical.
    function automatic int qdiff();
        int n;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
        if (got_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [7:0] b);
        int cnt;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        cnt = 0;
        while (bus.rx_ready !== 1'b1 && cnt < 20000) begin
            @(negedge clk);
            cnt++;
        end
        if (bus.rx_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL rx_ready_timeout: rx_ready=%b after %0d cycles, required 1", bus.rx_ready, cnt);
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
        model_byte(b);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.rx_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic drain();
        repeat (3) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        checks++;
        if ({bus.wr_en, bus.busy, bus.rx_ready} !== 3'b001) begin
            errors++; $display("FAIL reset_ctrl: wr_en,busy,rx_ready=%b required 001", {bus.wr_en, bus.busy, bus.rx_ready});
        end
        checks++;
        if ({bus.wr_addr, bus.wr_data} !== '0) begin
            errors++; $display("FAIL reset_wr: addr=%0d data=%h required 0/00", bus.wr_addr, bus.wr_data);
        end
        do_reset();
        @(negedge clk);
        checks++;
        if ({bus.cur_x, bus.cur_y, bus.cur_addr} !== '0 || bus.rx_ready !== 1'b1) begin
            errors++; $display("FAIL reset_cursor: x=%0d y=%0d a=%0d rdy=%b required 0,0,0,1", bus.cur_x, bus.cur_y, bus.cur_addr, bus.rx_ready);
        end
    endtask

    task automatic test_ab();
        int d;
        do_reset();
        send_str("AB");
        drain();
        checks++;
        if (got_q.size() != 2 || got_q[0] !== {13'd0, 8'h41} || got_q[1] !== {13'd1, 8'h42}) begin
            errors++; $display("FAIL ab_writes: %0d writes first=%h, required 2 writes 0041/0142", got_q.size(), got_q.size() > 0 ? got_q[0] : '0);
        end
        checks++;
        if (bus.cur_x !== 13'd2 || bus.cur_y !== 13'd0 || bus.cur_addr !== 13'd2) begin
            errors++; $display("FAIL ab_cursor: (%0d,%0d) a=%0d required (2,0) a=2", bus.cur_x, bus.cur_y, bus.cur_addr);
        end
        d = qdiff();
        checks++;
        if (d >= 0) begin errors++; $display("FAIL ab_model: first diff at write %0d", d); end
    endtask

    task automatic test_row_wrap();
        int d;
        do_reset();
        for (int i = 0; i < COLS; i++) send(8'($urandom_range(32, 126)));
        send("Z");
        drain();
        checks++;
        if (bus.cur_x !== 13'd1 || bus.cur_y !== 13'd1) begin
            errors++; $display("FAIL row_wrap_cursor: (%0d,%0d) required (1,1)", bus.cur_x, bus.cur_y);
        end
        checks++;
        if (got_q.size() != COLS + 1 || got_q[got_q.size()-1] !== {13'd80, 8'h5A}) begin
            errors++; $display("FAIL row_wrap_Z: %0d writes, required 81 ending 80/5a", got_q.size());
        end
        d = qdiff();
        checks++;
        if (d >= 0) begin errors++; $display("FAIL row_wrap_model: first diff at write %0d", d); end
    endtask

    task automatic test_csi_moves();
        do_reset();
        send(8'h1B); send_str("[A");
        checks++;
        if (bus.cur_x !== 13'd0 || bus.cur_y !== 13'd59) begin
            errors++; $display("FAIL csi_up_wrap: (%0d,%0d) required (0,59)", bus.cur_x, bus.cur_y);
        end
        send(8'h1B); send_str("[D");
        checks++;
        if (bus.cur_x !== 13'd79 || bus.cur_y !== 13'd59 || bus.cur_addr !== 13'd4799) begin
            errors++; $display("FAIL csi_left_wrap: (%0d,%0d) a=%0d required (79,59) a=4799", bus.cur_x, bus.cur_y, bus.cur_addr);
        end
        send("!");
        checks++;
        if (bus.cur_x !== 13'd0 || bus.cur_y !== 13'd0) begin
            errors++; $display("FAIL screen_wrap: (%0d,%0d) required (0,0)", bus.cur_x, bus.cur_y);
        end
        repeat (5) send(8'h0A);
        send(8'h1B); send_str("[D");
        drain();
        checks++;
        if (bus.cur_x !== 13'd79 || bus.cur_y !== 13'd5) begin
            errors++; $display("FAIL csi_left_row5: (%0d,%0d) required (79,5)", bus.cur_x, bus.cur_y);
        end
        checks++;
        if (got_q.size() != 1 || got_q[0] !== {13'd4799, 8'h21}) begin
            errors++; $display("FAIL csi_no_writes: %0d writes, required exactly one 4799/21", got_q.size());
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic [7:0] finals [5] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h48};
        logic [7:0] ctrls  [6] = '{8'h0D, 8'h0A, 8'h08, 8'h7F, 8'h00, 8'h1B};
        int d;
        int bad;
        do_reset();
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: b = 8'($urandom_range(32, 126));
                4:          b = 8'h1B;
                5:          b = 8'h5B;
                6:          b = finals[$urandom_range(0, 4)];
                7:          b = 8'($urandom_range(48, 57));
                8:          b = ctrls[$urandom_range(0, 5)];
                default:    b = 8'($urandom_range(0, 255));
            endcase
            if (b == 8'h4A) b = 8'h48;
            send(b);
            checks++;
            if (bus.cur_x !== AW'(mx) || bus.cur_y !== AW'(my) || bus.cur_addr !== AW'(my * COLS + mx)) begin
                errors++;
                if (bad < 5) $display("FAIL rand_cursor: byte %0d=%h got (%0d,%0d) a=%0d required (%0d,%0d) a=%0d",
                                      i, b, bus.cur_x, bus.cur_y, bus.cur_addr, mx, my, my * COLS + mx);
                bad++;
            end
        end
        drain();
        d = qdiff();
        checks++;
        if (d >= 0) begin errors++; $display("FAIL rand_writes: first diff at write %0d (got %0d, required %0d writes)", d, got_q.size(), exp_q.size()); end
    endtask

    task automatic test_clear();
        int low;
        int d;
        do_reset();
        send_str("hi"); send(8'h0A);
        got_q.delete(); exp_q.delete();
        send(8'h1B); send_str("[2");
        send("J");
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL clear_busy: busy=%b required 1", bus.busy); end
        low = 0;
        while (bus.rx_ready !== 1'b1 && low < 6000) begin
            low++;
            @(negedge clk);
        end
        checks++;
        if (low != NCELL) begin errors++; $display("FAIL clear_len: rx_ready low %0d cycles, required %0d", low, NCELL); end
        drain();
        checks++;
        if (bus.busy !== 1'b0 || bus.cur_x !== 13'd0 || bus.cur_y !== 13'd0) begin
            errors++; $display("FAIL clear_end: busy=%b (%0d,%0d) required 0 (0,0)", bus.busy, bus.cur_x, bus.cur_y);
        end
        checks++;
        if (got_q.size() != NCELL || got_q[NCELL-1] !== {13'd4799, 8'h20} || got_q[0] !== {13'd0, 8'h20}) begin
            errors++; $display("FAIL clear_writes: %0d writes, required 4800 of 20 at 0..4799", got_q.size());
        end
        d = qdiff();
        checks++;
        if (d >= 0) begin errors++; $display("FAIL clear_model: first diff at write %0d", d); end
        checks++;
        if (bus.wr_en !== 1'b0 || bus.wr_addr !== 13'd4799 || bus.wr_data !== 8'h20) begin
            errors++; $display("FAIL clear_hold: wr_en=%b addr=%0d data=%h required 0/4799/20", bus.wr_en, bus.wr_addr, bus.wr_data);
        end
    endtask

    task automatic test_reset_mid_clear();
        do_reset();
        send_str("xyz");
        send(8'h1B); send_str("[J");
        repeat (100) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.rx_ready !== 1'b1 || bus.cur_x !== 13'd0 || bus.cur_y !== 13'd0 || bus.wr_en !== 1'b0) begin
            errors++; $display("FAIL mid_clear_reset: busy=%b rdy=%b (%0d,%0d) wr_en=%b required 0 1 (0,0) 0",
                               bus.busy, bus.rx_ready, bus.cur_x, bus.cur_y, bus.wr_en);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        got_q.delete(); exp_q.delete();
        send("Q");
        drain();
        checks++;
        if (got_q.size() != 1 || got_q[0] !== {13'd0, 8'h51}) begin
            errors++; $display("FAIL post_reset_write: %0d writes, required one 0/51", got_q.size());
        end
    endtask

`ifdef TERM_CSI_COUNT_EN
    task automatic test_count();
        do_reset();
        repeat (3) send(8'h0A);
        repeat (75) send("x");
        send(8'h1B); send_str("[12C");
        checks++;
        if (bus.cur_x !== 13'd7 || bus.cur_y !== 13'd3) begin
            errors++; $display("FAIL count_right: (%0d,%0d) required (7,3)", bus.cur_x, bus.cur_y);
        end
        send(8'h1B); send_str("[5J");
        @(negedge clk);
        checks++;
        if (bus.rx_ready !== 1'b1 || bus.busy !== 1'b0 || bus.cur_x !== 13'd7) begin
            errors++; $display("FAIL count_j5: rdy=%b busy=%b x=%0d required 1 0 7", bus.rx_ready, bus.busy, bus.cur_x);
        end
        send(8'h1B); send_str("[999C");
        checks++;
        if (bus.cur_x !== 13'd26 || bus.cur_y !== 13'd3) begin
            errors++; $display("FAIL count_sat: (%0d,%0d) required (26,3)", bus.cur_x, bus.cur_y);
        end
    endtask
`endif

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        model_reset();
        #3;
        test_reset();
        test_ab();
        test_row_wrap();
        test_csi_moves();
        test_random();
        test_clear();
        test_reset_mid_clear();
`ifdef TERM_CSI_COUNT_EN
        test_count();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
